// File: rtl/guess_pkg.sv
// Shared definitions for the guessing-game datapath: the BCD digit type, the
// display blank code, the entry FSM state encoding and the switch-to-digit clamp.
package guess_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // Display code that the 7-seg decoder renders as an unlit digit.
  localparam bcd_t BLANK = 4'hF;

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Switch values 10..15 are not decimal digits; saturate them to 9.
  function automatic bcd_t clamp_bcd(input logic [3:0] sw);
    return (sw > 4'd9) ? 4'd9 : sw;
  endfunction

endpackage

// File: rtl/bin2bcd2.sv
// Two-digit binary-to-BCD converter (combinational).
// Ports:
//   i_bin   : 7-bit binary value, 0..MAX_VAL (MAX_VAL <= 99)
//   o_tens  : BCD tens digit
//   o_ones  : BCD ones digit
// The tens digit is found with a short compare chain bounded by MAX_VAL, so a
// small MAX_VAL builds only the comparators it needs.
module bin2bcd2 #(
  parameter int MAX_VAL = 99
) (
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [6:0] w_rem;

  always_comb begin
    o_tens = 4'd0;
    for (int k = 1; k <= MAX_VAL / 10; k++) begin
      if (i_bin >= 7'(10 * k)) o_tens = 4'(k);
    end
    w_rem  = i_bin - 7'(10 * o_tens);
    o_ones = w_rem[3:0];
  end

endmodule

// File: rtl/manual_entry_ctrl.sv
// Manual guess entry controller.
// Collects NUM_DIGITS BCD digits and a trial count from four switches, using a
// digit cursor, a load pulse and a submit/ack handshake toward the compare logic.
// Also drives the digit display bus with a blinking cursor.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   SW              : switch value written by load
//   load/next/prev  : 1-cycle pulses (write, cursor +1, cursor -1)
//   set_trials      : level, 1 = edit trial count, 0 = edit guess digits
//   submit, ack     : offer guess downstream / downstream accepted it
//   manual_data     : submitted guess, digit 0 in [3:0]
//   valid           : manual_data held and valid
//   trials          : trial count, binary
//   cursor          : current digit index
//   out             : display codes per digit, 4'hF = blank
module manual_entry_ctrl
  import guess_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIALS     = 15,
  parameter int DEFAULT_TRIALS = 5,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              SW,
  input  logic                    load,
  input  logic                    next,
  input  logic                    prev,
  input  logic                    set_trials,
  input  logic                    submit,
  input  logic                    ack,
  output logic [4*NUM_DIGITS-1:0] manual_data,
  output logic                    valid,
  output logic [6:0]              trials,
  output logic [2:0]              cursor,
  output logic [4*NUM_DIGITS-1:0] out
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int               CNT_W    = $clog2(BLINK_DIV);
  localparam logic [2:0]       CUR_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  state_t                  r_state;
  bcd_t [NUM_DIGITS-1:0]   r_digits;
  bcd_t [NUM_DIGITS-1:0]   r_manual;
  logic                    r_valid;
  logic [6:0]              r_trials;
  logic [2:0]              r_cursor;
  logic [CNT_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_out;

  bcd_t [NUM_DIGITS-1:0]   w_disp;
  bcd_t                    w_tens;
  bcd_t                    w_ones;
  logic [IDX_W-1:0]        w_idx;

  // SW = 0 still leaves one trial; values above MAX_TRIALS saturate.
  function automatic logic [6:0] clamp_trials(input logic [3:0] sw);
    if (sw == 4'd0) return 7'd1;
    if ({3'd0, sw} > 7'(MAX_TRIALS)) return 7'(MAX_TRIALS);
    return {3'd0, sw};
  endfunction

  assign w_idx = r_cursor[IDX_W-1:0];

  // Entry FSM: edits digits/trials/cursor in EDIT, freezes everything in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EDIT;
      r_digits <= '0;
      r_manual <= '0;
      r_valid  <= 1'b0;
      r_trials <= 7'(DEFAULT_TRIALS);
      r_cursor <= 3'd0;
    end else begin
      case (r_state)
        EDIT: begin
          // The write addresses the cursor value from before any move this cycle.
          if (load) begin
            if (set_trials) r_trials <= clamp_trials(SW);
            else            r_digits[w_idx] <= clamp_bcd(SW);
          end
          // Simultaneous next and prev cancel out.
          if (!set_trials && (next != prev)) begin
            if (next) r_cursor <= (r_cursor == CUR_LAST) ? 3'd0 : r_cursor + 3'd1;
            else      r_cursor <= (r_cursor == 3'd0) ? CUR_LAST : r_cursor - 3'd1;
          end
          // Snapshot takes the digits as they stand before a same-cycle load.
          if (submit && !set_trials) begin
            r_manual <= r_digits;
            r_valid  <= 1'b1;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= EDIT;
          end
        end
        default: r_state <= EDIT;
      endcase
    end
  end

  // Any edit action restarts the blink in its visible half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (load || next || prev) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  bin2bcd2 #(
    .MAX_VAL(MAX_TRIALS)
  ) u_trials_bcd (
    .i_bin (r_trials),
    .o_tens(w_tens),
    .o_ones(w_ones)
  );

  always_comb begin
    w_disp = '0;
    if (set_trials) begin
      w_disp[0] = w_ones;
      w_disp[1] = w_tens;
    end else begin
      w_disp = r_digits;
      if (r_state == EDIT && r_blink_phase) w_disp[w_idx] = BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= '0;
    else     r_out <= w_disp;
  end

  assign manual_data = r_manual;
  assign valid       = r_valid;
  assign trials      = r_trials;
  assign cursor      = r_cursor;
  assign out         = r_out;

endmodule

// File: tb/tb_manual_entry_ctrl.sv
module tb_manual_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  SW = '0;
  logic        load = 0, next = 0, prev = 0, set_trials = 0, submit = 0, ack = 0;

  logic [15:0] manual_data, out, manual_data2, out2;
  logic        valid, valid2;
  logic [6:0]  trials, trials2;
  logic [2:0]  cursor, cursor2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  manual_entry_ctrl #(
    .NUM_DIGITS(4), .MAX_TRIALS(15), .DEFAULT_TRIALS(5), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .SW(SW), .load(load), .next(next), .prev(prev),
    .set_trials(set_trials), .submit(submit), .ack(ack),
    .manual_data(manual_data), .valid(valid), .trials(trials),
    .cursor(cursor), .out(out)
  );

  // Same stimulus, lower trial clamp.
  manual_entry_ctrl #(
    .NUM_DIGITS(4), .MAX_TRIALS(10), .DEFAULT_TRIALS(5), .BLINK_DIV(4)
  ) dut10 (
    .clk(clk), .rst(rst), .SW(SW), .load(load), .next(next), .prev(prev),
    .set_trials(set_trials), .submit(submit), .ack(ack),
    .manual_data(manual_data2), .valid(valid2), .trials(trials2),
    .cursor(cursor2), .out(out2)
  );

  typedef struct {
    logic [3:0]  sw;
    logic        ld, nx, pv, st, sb, ak;
    logic        vld;
    logic [15:0] md;
    logic [2:0]  cur;
    logic [6:0]  tr;
    logic [6:0]  tr10;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] sw, input logic ld, nx, pv, st, sb, ak,
                     input logic vld, input logic [15:0] md, input logic [2:0] cur,
                     input logic [6:0] tr, input logic [6:0] tr10, input logic [15:0] dout);
    vec_t v;
    v.sw = sw; v.ld = ld; v.nx = nx; v.pv = pv; v.st = st; v.sb = sb; v.ak = ak;
    v.vld = vld; v.md = md; v.cur = cur; v.tr = tr; v.tr10 = tr10; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sw, input logic ld, nx, pv, st, sb, ak);
    SW = sw; load = ld; next = nx; prev = pv; set_trials = st; submit = sb; ack = ak;
  endtask

  task automatic idle_cycle();
    drive(4'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    //   sw  ld nx pv st sb ak | vld md        cur tr  tr10 out
    add(4'd0,  0, 0, 0, 0, 0, 0,  0, 16'h0000, 3'd0, 7'd5,  7'd5,  16'h0000);
    add(4'd7,  1, 0, 0, 0, 0, 0,  0, 16'h0000, 3'd0, 7'd5,  7'd5,  16'h0000);
    add(4'd0,  0, 1, 0, 0, 0, 0,  0, 16'h0000, 3'd1, 7'd5,  7'd5,  16'h0007);
    add(4'd12, 1, 0, 0, 0, 0, 0,  0, 16'h0000, 3'd1, 7'd5,  7'd5,  16'h0007);
    add(4'd0,  0, 0, 0, 0, 1, 0,  1, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd3,  1, 0, 0, 0, 0, 0,  1, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 1, 0, 0, 0, 0,  1, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 0, 0, 0, 1, 0,  1, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 0, 0, 0, 0, 1,  0, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 1, 1, 0, 0, 0,  0, 16'h0097, 3'd1, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 0, 1, 0, 0, 0,  0, 16'h0097, 3'd0, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 0, 1, 0, 0, 0,  0, 16'h0097, 3'd3, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 1, 0, 0, 0, 0,  0, 16'h0097, 3'd0, 7'd5,  7'd5,  16'h0097);
    add(4'd0,  0, 0, 0, 0, 0, 1,  0, 16'h0097, 3'd0, 7'd5,  7'd5,  16'h0097);
    add(4'd12, 1, 0, 0, 1, 0, 0,  0, 16'h0097, 3'd0, 7'd12, 7'd10, 16'h0005);
    add(4'd0,  0, 1, 0, 1, 0, 0,  0, 16'h0097, 3'd0, 7'd12, 7'd10, 16'h0012);
    add(4'd0,  0, 0, 0, 1, 1, 0,  0, 16'h0097, 3'd0, 7'd12, 7'd10, 16'h0012);
    add(4'd0,  1, 0, 0, 1, 0, 0,  0, 16'h0097, 3'd0, 7'd1,  7'd1,  16'h0012);
    add(4'd0,  0, 0, 0, 1, 0, 0,  0, 16'h0097, 3'd0, 7'd1,  7'd1,  16'h0001);
    add(4'd15, 1, 0, 0, 1, 0, 0,  0, 16'h0097, 3'd0, 7'd15, 7'd10, 16'h0001);
    add(4'd0,  0, 0, 0, 0, 0, 0,  0, 16'h0097, 3'd0, 7'd15, 7'd10, 16'h0097);

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_valid",  {31'd0, valid}, 32'd0);
    check("rst_manual", {16'd0, manual_data}, 32'd0);
    check("rst_cursor", {29'd0, cursor}, 32'd0);
    check("rst_trials", {25'd0, trials}, 32'd5);
    check("rst_out",    {16'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sw, vecs[i].ld, vecs[i].nx, vecs[i].pv, vecs[i].st, vecs[i].sb, vecs[i].ak);
      @(negedge clk);
      check($sformatf("v%0d_valid", i),  {31'd0, valid},       {31'd0, vecs[i].vld});
      check($sformatf("v%0d_manual", i), {16'd0, manual_data}, {16'd0, vecs[i].md});
      check($sformatf("v%0d_cursor", i), {29'd0, cursor},      {29'd0, vecs[i].cur});
      check($sformatf("v%0d_trials", i), {25'd0, trials},      {25'd0, vecs[i].tr});
      check($sformatf("v%0d_trials10", i), {25'd0, trials2},   {25'd0, vecs[i].tr10});
      check($sformatf("v%0d_out", i),    {16'd0, out},         {16'd0, vecs[i].dout});
    end

    // Blink: next moves cursor to 1 and restarts the phase; digit 1 (the 9)
    // is blanked for display cycles 5..8 after the pulse.
    drive(4'd0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("blink_cursor", {29'd0, cursor}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      idle_cycle();
      check($sformatf("blink_k%0d", k), {16'd0, out},
            (k >= 5 && k <= 8) ? 32'h00F7 : 32'h0097);
    end
    idle_cycle();
    check("blink_blank_again", {16'd0, out}, 32'h00F7);
    drive(4'd0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("blink_next_lag", {16'd0, out}, 32'h00F7);
    idle_cycle();
    check("blink_restart_visible", {16'd0, out}, 32'h0097);
    check("blink_restart_cursor", {29'd0, cursor}, 32'd2);

    // Reset while holding a submitted guess.
    drive(4'd0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_manual", {16'd0, manual_data}, 32'h0097);
    drive(4'd0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("arst_valid",  {31'd0, valid}, 32'd0);
    check("arst_manual", {16'd0, manual_data}, 32'd0);
    check("arst_cursor", {29'd0, cursor}, 32'd0);
    check("arst_trials", {25'd0, trials}, 32'd5);
    check("arst_out",    {16'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/manual_entry_ctrl.md
Name: manual_entry_ctrl

Overview:
- Clocked, parametrised successor of the guessing-game switch-entry block.
- Accepts NUM_DIGITS BCD digits and the trial count from 4 switches, using a cursor, a per-digit load pulse and a submit/ack handshake.
- Drives the 7-seg digit bus with a blinking cursor.
- Sits between the debounced button/switch front-end and the submit/compare logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in a guess (2..8).
- MAX_TRIALS, 15, upper clamp for the trial count (1..99).
- DEFAULT_TRIALS, 5, trial count after reset.
- BLINK_DIV, 25000000, clk cycles per cursor blink half-period (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- SW  input  4  switch value.
- load  input  1  1-cycle pulse: write SW to the current target.
- next  input  1  1-cycle pulse: cursor +1.
- prev  input  1  1-cycle pulse: cursor -1.
- set_trials  input  1  level: 1 = edit trial count, 0 = edit guess digits.
- submit  input  1  1-cycle pulse: offer the guess downstream.
- ack  input  1  downstream accepted the guess.
- manual_data  output  4*NUM_DIGITS  submitted guess; digit 0 in [3:0].
- valid  output  1  manual_data held and valid.
- trials  output  7  current trial count, binary.
- cursor  output  3  current digit index.
- out  output  4*NUM_DIGITS  display codes; 4'hF = blank.

Behaviour:
- Reset (async, rst=1):
  - edit digits, manual_data, cursor and blink counter = 0.
  - valid = 0; trials = DEFAULT_TRIALS; FSM = EDIT.
  - out = all zero digits.
- FSM EDIT:
  - load with set_trials=0: edit digit[cursor] <= min(SW,9) at the next edge.
  - load with set_trials=1: trials <= clamp(SW, 1, MAX_TRIALS). SW=0 gives 1.
  - next: cursor <= (cursor==NUM_DIGITS-1) ? 0 : cursor+1.
  - prev: cursor <= (cursor==0) ? NUM_DIGITS-1 : cursor-1.
  - next and prev together: cursor unchanged.
  - load together with next/prev: the write uses the old cursor, then the cursor moves.
  - Cursor moves only when set_trials=0.
  - submit with set_trials=0: manual_data <= edit digits snapshot; valid <= 1; go to HOLD. Latency 1 cycle.
  - submit with set_trials=1: ignored.
- FSM HOLD:
  - manual_data and valid stable.
  - load, next, prev and submit ignored.
  - ack=1 sampled at an edge: valid <= 0, back to EDIT.
  - Edit digits are not cleared.
  - ack in EDIT: ignored.
- Display (registered, 1-cycle latency from the state change):
  - set_trials=0: out digit i = edit digit i. The cursor digit is replaced by 4'hF while blink_phase=1.
  - In HOLD there is no blinking; all digits are shown.
  - set_trials=1: out[3:0] = trials mod 10, out[7:4] = trials / 10, higher digits 0, no blink.
- Blink:
  - Counter counts 0..BLINK_DIV-1, then wraps and toggles blink_phase.
  - Counter and phase reset to 0 on any next, prev or load, so the cursor stays visible while editing.
- Mode switch: toggling set_trials mid-edit preserves the edit digits, cursor and trials.
- Reset mid-HOLD: valid drops immediately (async).
- Widths:
  - All digit values are 0..9.
  - The trials BCD split is done with a MAX_TRIALS-bounded divide-by-10, combinational feeding the out register.

Decomposition:
- Shared package guess_pkg holds:
  - DIGIT_W=4, BLANK=4'hF.
  - typedef bcd_t.
  - state enum {EDIT, HOLD}.
  - function clamp_bcd(sw) = min(sw,9).
- One natural sub-module: bin2bcd2 (7-bit binary 0..99 to two BCD digits), reused by the score/trials display elsewhere.

Test Plan:
- Reset, then SW=7 load, next, SW=12 load, submit → manual_data=16'h0097 one cycle later, valid=1.
- With valid=1: load/next/submit ignored; ack pulse → valid=0 next edge; edit digits still show 7,9.
- Cursor wrap: from 0, prev → 3; from 3, next → 0; next+prev same cycle → unchanged.
- set_trials=1: SW=12 load → trials=12, out=16'h0012. SW=0 load → trials=1. With MAX_TRIALS=10, SW=15 load → trials=10.
- Blink with BLINK_DIV=4: the cursor digit shows 4'hF for 4 cycles every 8. A next pulse restarts the phase with the digit visible.
- Assert rst during HOLD → valid, manual_data and cursor return to 0 without a clock edge; trials=5.
